// File: rtl/rob_complete_arbiter_pkg.sv
// rtl/rob_complete_arbiter_pkg.sv - shared widths and completion packet types
//
// Purpose: common definitions for the ROB completion arbiter slice.
//   ROB_SZ / ROB_IDX_W : ROB depth and index width
//   XLEN               : datapath width
//   TAG_W              : physical tag width including its valid bit
//   fu_complete_t      : one FU completion {rob_idx, result, rs2_value, take_branch, tag}
//   ic_rob_packet_t    : the same bundle as presented on the ROB complete port
package rob_complete_arbiter_pkg;

  localparam int ROB_SZ    = 32;
  localparam int ROB_IDX_W = $clog2(ROB_SZ);
  localparam int XLEN      = 32;
  localparam int TAG_W     = 6;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [XLEN-1:0]      result;
    logic [XLEN-1:0]      rs2_value;
    logic                 take_branch;
    logic [TAG_W-1:0]     tag;
  } fu_complete_t;

  // The output register carries exactly what a slot holds.
  typedef fu_complete_t ic_rob_packet_t;

  // Round-robin pointer advance: the slot after v, wrapping at n.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rob_complete_arbiter_rr_arbiter.sv
// rtl/rob_complete_arbiter_rr_arbiter.sv - combinational round-robin picker
//
// Purpose: choose the first set request starting at i_ptr and wrapping.
// Ports:
//   i_req        in   N    request vector
//   i_ptr        in   PW   highest-priority position this cycle
//   o_grant      out  N    one-hot grant (zero when no request)
//   o_grant_idx  out  PW   binary index of the granted requester
module rob_complete_arbiter_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_grant_idx
);

  localparam int            W2  = 2 * N;
  localparam logic [W2-1:0] ONE = W2'(1);

  logic [W2-1:0] w_req2;
  logic [W2-1:0] w_keep;
  logic [W2-1:0] w_masked;
  logic          w_found;
  logic [PW:0]   w_hit;

  // Requests are laid out twice. Bits below the pointer are masked in the
  // low copy only, so their twins in the high copy stand in for the wrapped
  // positions; the lowest surviving bit is the next requester at/after ptr.
  assign w_req2   = {i_req, i_req};
  assign w_keep   = ~((ONE << i_ptr) - ONE);
  assign w_masked = w_req2 & w_keep;

  always_comb begin
    w_found = 1'b0;
    w_hit   = '0;
    for (int k = 0; k < W2; k++) begin
      if (!w_found && w_masked[k]) begin
        w_found = 1'b1;
        w_hit   = (PW+1)'(k);
      end
    end
  end

  assign o_grant_idx = (w_hit >= (PW+1)'(N)) ? PW'(w_hit - (PW+1)'(N)) : PW'(w_hit);
  assign o_grant     = w_found ? (N'(1) << o_grant_idx) : '0;

endmodule

// File: rtl/rob_complete_arbiter.sv
// rtl/rob_complete_arbiter.sv - merges FU completions onto the single ROB complete port
//
// Purpose: each FU owns a one-entry holding slot; a round-robin arbiter moves
// one valid slot per cycle into a registered output toward the ROB/CDB.
// Ports:
//   clock, reset             clock and synchronous active-high reset
//   interrupt                synchronous flush, same effect as reset
//   fu_valid / fu_ready      per-FU handshake (transfer when both high)
//   fu_rob_idx, fu_result, fu_rs2_value, fu_take_branch, fu_tag
//                            per-FU completion fields, FU i at [i*W +: W]
//   out_stall                downstream cannot take the current output
//   complete_en, complete_idx, complete_result, complete_rs2_value,
//   complete_take_branch, complete_tag
//                            registered completion presented to the ROB
//   complete_fu              registered one-hot source of the current output
module rob_complete_arbiter
  import rob_complete_arbiter_pkg::*;
#(
  parameter int NUM_FU = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        interrupt,
  input  logic [NUM_FU-1:0]           fu_valid,
  output logic [NUM_FU-1:0]           fu_ready,
  input  logic [NUM_FU*ROB_IDX_W-1:0] fu_rob_idx,
  input  logic [NUM_FU*XLEN-1:0]      fu_result,
  input  logic [NUM_FU*XLEN-1:0]      fu_rs2_value,
  input  logic [NUM_FU-1:0]           fu_take_branch,
  input  logic [NUM_FU*TAG_W-1:0]     fu_tag,
  input  logic                        out_stall,
  output logic                        complete_en,
  output logic [ROB_IDX_W-1:0]        complete_idx,
  output logic [XLEN-1:0]             complete_result,
  output logic [XLEN-1:0]             complete_rs2_value,
  output logic                        complete_take_branch,
  output logic [TAG_W-1:0]            complete_tag,
  output logic [NUM_FU-1:0]           complete_fu
);

  localparam int PW = $clog2(NUM_FU);

  fu_complete_t      w_fu_in [NUM_FU];
  fu_complete_t      r_slot  [NUM_FU];
  logic [NUM_FU-1:0] r_slot_valid;
  logic [PW-1:0]     r_rr_ptr;

  ic_rob_packet_t    r_out;
  logic              r_complete_en;
  logic [NUM_FU-1:0] r_complete_fu;

  logic              w_flush;
  logic              w_out_ld;
  logic [NUM_FU-1:0] w_req;
  logic [NUM_FU-1:0] w_grant;
  logic [PW-1:0]     w_grant_idx;
  logic [NUM_FU-1:0] w_take;

  genvar g;
  generate
    for (g = 0; g < NUM_FU; g++) begin : g_unpack
      assign w_fu_in[g] = '{
        rob_idx:     fu_rob_idx[g*ROB_IDX_W +: ROB_IDX_W],
        result:      fu_result[g*XLEN +: XLEN],
        rs2_value:   fu_rs2_value[g*XLEN +: XLEN],
        take_branch: fu_take_branch[g],
        tag:         fu_tag[g*TAG_W +: TAG_W]
      };
    end
  endgenerate

  assign w_flush = reset | interrupt;

  // The output register may take a new value when it is empty or being
  // consumed; an empty register fills even while downstream stalls.
  assign w_out_ld = !r_complete_en || !out_stall;
  assign w_req    = r_slot_valid & {NUM_FU{w_out_ld}};

  rob_complete_arbiter_rr_arbiter #(
    .N  (NUM_FU),
    .PW (PW)
  ) u_rr_arbiter (
    .i_req       (w_req),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  // A slot being granted this cycle can be refilled on the same edge, which
  // is what lets a single FU stream one completion per cycle.
  assign fu_ready = w_flush ? '0 : (~r_slot_valid | w_grant);
  assign w_take   = fu_valid & fu_ready;

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (w_flush) begin
        r_slot_valid[i] <= 1'b0;
      end else if (w_take[i]) begin
        r_slot_valid[i] <= 1'b1;
        r_slot[i]       <= w_fu_in[i];
      end else if (w_grant[i]) begin
        r_slot_valid[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_flush) begin
      r_out         <= '0;
      r_complete_en <= 1'b0;
      r_complete_fu <= '0;
      r_rr_ptr      <= '0;
    end else if (w_out_ld) begin
      if (|w_grant) begin
        r_out         <= r_slot[w_grant_idx];
        r_complete_en <= 1'b1;
        r_complete_fu <= w_grant;
        r_rr_ptr      <= PW'(wrap_inc(int'(w_grant_idx), NUM_FU));
      end else begin
        // Data fields keep stale contents; complete_en qualifies them.
        r_complete_en <= 1'b0;
        r_complete_fu <= '0;
      end
    end
  end

  assign complete_en          = r_complete_en;
  assign complete_idx         = r_out.rob_idx;
  assign complete_result      = r_out.result;
  assign complete_rs2_value   = r_out.rs2_value;
  assign complete_take_branch = r_out.take_branch;
  assign complete_tag         = r_out.tag;
  assign complete_fu          = r_complete_fu;

endmodule

// File: tb/tb_rob_complete_arbiter.sv
// tb/tb_rob_complete_arbiter.sv - scoreboard bench for rob_complete_arbiter
module tb_rob_complete_arbiter;
  import rob_complete_arbiter_pkg::*;

  localparam int NUM_FU = 4;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] idx;
    logic [XLEN-1:0]      result;
    logic [XLEN-1:0]      rs2;
    logic                 tb;
    logic [TAG_W-1:0]     tag;
    logic [NUM_FU-1:0]    fu;
  } item_t;

  logic                        clock;
  logic                        reset;
  logic                        interrupt;
  logic [NUM_FU-1:0]           fu_valid;
  logic [NUM_FU-1:0]           fu_ready;
  logic [NUM_FU*ROB_IDX_W-1:0] fu_rob_idx;
  logic [NUM_FU*XLEN-1:0]      fu_result;
  logic [NUM_FU*XLEN-1:0]      fu_rs2_value;
  logic [NUM_FU-1:0]           fu_take_branch;
  logic [NUM_FU*TAG_W-1:0]     fu_tag;
  logic                        out_stall;
  logic                        complete_en;
  logic [ROB_IDX_W-1:0]        complete_idx;
  logic [XLEN-1:0]             complete_result;
  logic [XLEN-1:0]             complete_rs2_value;
  logic                        complete_take_branch;
  logic [TAG_W-1:0]            complete_tag;
  logic [NUM_FU-1:0]           complete_fu;

  int    n_chk  = 0;
  int    n_fail = 0;
  item_t fu_q [NUM_FU][$];
  item_t exp_q [$];
  item_t mon_e;
  logic  drv_all;
  logic [NUM_FU-1:0] drv_xfer;

  rob_complete_arbiter #(.NUM_FU(NUM_FU)) dut (
    .clock                (clock),
    .reset                (reset),
    .interrupt            (interrupt),
    .fu_valid             (fu_valid),
    .fu_ready             (fu_ready),
    .fu_rob_idx           (fu_rob_idx),
    .fu_result            (fu_result),
    .fu_rs2_value         (fu_rs2_value),
    .fu_take_branch       (fu_take_branch),
    .fu_tag               (fu_tag),
    .out_stall            (out_stall),
    .complete_en          (complete_en),
    .complete_idx         (complete_idx),
    .complete_result      (complete_result),
    .complete_rs2_value   (complete_rs2_value),
    .complete_take_branch (complete_take_branch),
    .complete_tag         (complete_tag),
    .complete_fu          (complete_fu)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic item_t mk(input int f, input int idx, input logic [31:0] res);
    item_t it;
    it.idx    = ROB_IDX_W'(idx);
    it.result = res;
    it.rs2    = res ^ 32'hFFFF_0000;
    it.tb     = idx[0] ^ f[0];
    it.tag    = {1'b1, it.idx};
    it.fu     = NUM_FU'(1 << f);
    return it;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_en(input int budget, input string tag);
    int n = 0;
    @(negedge clock);
    while (!complete_en && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_timeout"}, complete_en, 1'b1);
  endtask

  // FU model: presents the head of its queue, advances on a handshake.
  initial begin
    item_t h;
    fu_valid       = '0;
    fu_rob_idx     = '0;
    fu_result      = '0;
    fu_rs2_value   = '0;
    fu_take_branch = '0;
    fu_tag         = '0;
    forever begin
      @(negedge clock);
      drv_xfer = fu_valid & fu_ready;
      @(posedge clock);
      #2;
      for (int f = 0; f < NUM_FU; f++) begin
        if (drv_xfer[f] && fu_q[f].size() > 0) fu_q[f].delete(0);
        if (drv_all) begin
          fu_valid[f] = 1'b1;
        end else if (fu_q[f].size() > 0) begin
          h = fu_q[f][0];
          fu_valid[f]                        = 1'b1;
          fu_rob_idx[f*ROB_IDX_W +: ROB_IDX_W] = h.idx;
          fu_result[f*XLEN +: XLEN]          = h.result;
          fu_rs2_value[f*XLEN +: XLEN]       = h.rs2;
          fu_take_branch[f]                  = h.tb;
          fu_tag[f*TAG_W +: TAG_W]           = h.tag;
        end else begin
          fu_valid[f] = 1'b0;
        end
      end
    end
  end

  // A completion is consumed when it is valid and not stalled.
  always @(negedge clock) begin
    if (!reset && complete_en === 1'b1 && out_stall === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cpl", complete_en, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check("cpl_idx", complete_idx, mon_e.idx);
        check("cpl_result", complete_result, mon_e.result);
        check("cpl_rs2", complete_rs2_value, mon_e.rs2);
        check("cpl_branch", complete_take_branch, mon_e.tb);
        check("cpl_tag", complete_tag, mon_e.tag);
        check("cpl_fu", complete_fu, mon_e.fu);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    item_t it;
    logic [11:0] en_bits;
    reset     = 1'b1;
    interrupt = 1'b0;
    out_stall = 1'b0;
    drv_all   = 1'b1;

    // Reset with every FU requesting
    repeat (2) begin
      @(negedge clock);
      check("rst_ready", fu_ready, 4'b0000);
      check("rst_en", complete_en, 1'b0);
    end
    tick();
    reset   = 1'b0;
    drv_all = 1'b0;
    @(negedge clock);
    check("post_rst_en", complete_en, 1'b0);
    check("post_rst_ready", fu_ready, 4'b1111);
    @(negedge clock);
    check("post_rst_en2", complete_en, 1'b0);

    // Single completion from FU2, two-cycle latency, one cycle wide
    tick();
    it = mk(2, 5, 32'hDEAD_BEEF);
    fu_q[2].push_back(it);
    exp_q.push_back(it);
    @(negedge clock);
    check("t2_ready", fu_ready[2], 1'b1);
    @(negedge clock);
    check("t2_en_slot", complete_en, 1'b0);
    @(negedge clock);
    check("t2_en", complete_en, 1'b1);
    check("t2_idx", complete_idx, 5'd5);
    check("t2_result", complete_result, 32'hDEAD_BEEF);
    check("t2_fu", complete_fu, 4'b0100);
    @(negedge clock);
    check("t2_en_once", complete_en, 1'b0);

    // Contention: all FUs busy, rr pointer starts at 0 after reset
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int f = 0; f < NUM_FU; f++) begin
        it = mk(f, f, 32'h3000_0000 | (f << 8) | k);
        fu_q[f].push_back(it);
        exp_q.push_back(it);
      end
    end
    wait_en(20, "t3");
    for (int j = 0; j < 12; j++) begin
      check("t3_nobubble", complete_en, 1'b1);
      @(negedge clock);
    end
    check("t3_idle", complete_en, 1'b0);

    // Streaming from FU3 alone
    tick();
    for (int k = 0; k < 8; k++) begin
      it = mk(3, k, 32'h5000_0000 | k);
      fu_q[3].push_back(it);
      exp_q.push_back(it);
    end
    en_bits = '0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clock);
      if (j < 8) check("t5_ready", fu_ready[3], 1'b1);
      en_bits[j] = complete_en;
    end
    check("t5_pattern", en_bits, 12'b0011_1111_1100);

    // Stall with FU1 in the output and FU0/FU1 slots occupied
    do_reset();
    it = mk(1, 9, 32'h4000_0001);
    fu_q[1].push_back(it);
    exp_q.push_back(it);
    tick();
    it = mk(0, 11, 32'h4000_0000);
    fu_q[0].push_back(it);
    exp_q.push_back(it);
    it = mk(1, 10, 32'h4000_0011);
    fu_q[1].push_back(it);
    exp_q.push_back(it);
    tick();
    out_stall = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("t4_hold_en", complete_en, 1'b1);
      check("t4_hold_fu", complete_fu, 4'b0010);
      check("t4_hold_idx", complete_idx, 5'd9);
      check("t4_ready1", fu_ready[1], 1'b0);
      check("t4_ready0", fu_ready[0], 1'b0);
    end
    tick();
    out_stall = 1'b0;
    @(negedge clock);
    check("t4_rel_grant0", fu_ready[0], 1'b1);
    check("t4_rel_ready1", fu_ready[1], 1'b0);
    @(negedge clock);
    check("t4_next_fu", complete_fu, 4'b0001);
    repeat (3) @(negedge clock);

    // Stall while the output is empty still fills it
    tick();
    out_stall = 1'b1;
    it = mk(1, 12, 32'h7000_0012);
    fu_q[1].push_back(it);
    exp_q.push_back(it);
    @(negedge clock);
    @(negedge clock);
    check("t7_en_slot", complete_en, 1'b0);
    @(negedge clock);
    check("t7_fill_en", complete_en, 1'b1);
    check("t7_fill_fu", complete_fu, 4'b0010);
    @(negedge clock);
    check("t7_held_idx", complete_idx, 5'd12);
    tick();
    out_stall = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("t7_drained", complete_en, 1'b0);

    // Flush with slots 0,2 and the output occupied
    tick();
    fu_q[1].push_back(mk(1, 3, 32'h6000_0001));
    tick();
    fu_q[0].push_back(mk(0, 4, 32'h6000_0000));
    fu_q[2].push_back(mk(2, 6, 32'h6000_0002));
    tick();
    out_stall = 1'b1;
    @(negedge clock);
    check("t6_pre_en", complete_en, 1'b1);
    check("t6_pre_ready0", fu_ready[0], 1'b0);
    check("t6_pre_ready2", fu_ready[2], 1'b0);
    tick();
    interrupt = 1'b1;
    @(negedge clock);
    check("t6_flush_ready", fu_ready, 4'b0000);
    tick();
    interrupt = 1'b0;
    out_stall = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clock);
      check("t6_dropped", complete_en, 1'b0);
    end
    tick();
    it = mk(1, 20, 32'h6000_0020);
    fu_q[1].push_back(it);
    exp_q.push_back(it);
    @(negedge clock);
    @(negedge clock);
    check("t6_new_slot", complete_en, 1'b0);
    @(negedge clock);
    check("t6_new_en", complete_en, 1'b1);
    check("t6_new_fu", complete_fu, 4'b0010);
    repeat (3) @(negedge clock);

    check("sb_drain", exp_q.size(), 0);
    check("drv_drain", fu_q[0].size() + fu_q[1].size() + fu_q[2].size() + fu_q[3].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
